noc_packet_injector: RTL and testbench

//  Per-node, per-channel packet source feeding one in_flit/in_last/in_valid/in_ready slot of the mesh local port.

---
 rtl/noc_inject_pkg.sv | 40 ++++
 rtl/noc_flit_skid.sv | 81 ++++++++
 rtl/noc_packet_injector.sv | 184 ++++++++++++++++++
 tb/tb_noc_packet_injector.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_inject_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_inject_pkg
// Description : Shared types and header-layout helpers for the NoC packet
//               injector and the ejector-side header decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_inject_pkg;

  // Injector FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PAYLOAD = 2'd1;
  localparam state_t ST_DROP    = 2'd2;

  // Destination field width; a single-node mesh still carries a 1-bit field
  function automatic int dest_width(input int nodes);
    return (nodes > 1) ? $clog2(nodes) : 1;
  endfunction

  // Length field must hold 0..max_len inclusive
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Header layout, MSB first: {dest, src, len, zero padding}
  function automatic int hdr_dest_lsb(input int fw, input int dw);
    return fw - dw;
  endfunction

  function automatic int hdr_src_lsb(input int fw, input int dw);
    return fw - 2 * dw;
  endfunction

  function automatic int hdr_len_lsb(input int fw, input int dw, input int lw);
    return fw - 2 * dw - lw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_flit_skid.sv
`default_nettype none
// ============================================================================
// Module      : noc_flit_skid
// Description : Two-entry {flit,last} valid/ready buffer. Outputs come only
//               from the head register, so there is no combinational path
//               from the push side to the pop side. Sustains one flit per
//               cycle with simultaneous push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_flit_skid #(
  parameter int FLIT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,       // asynchronous, active-low
  input  logic [FLIT_WIDTH-1:0] i_flit,
  input  logic                  i_last,
  input  logic                  i_valid,
  output logic                  o_free,
  output logic [FLIT_WIDTH-1:0] o_flit,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_empty
);

  logic [FLIT_WIDTH-1:0] r_head_flit;
  logic                  r_head_last;
  logic                  r_head_valid;
  logic [FLIT_WIDTH-1:0] r_tail_flit;
  logic                  r_tail_last;
  logic                  r_tail_valid;
  logic                  w_push;
  logic                  w_pop;

  // A full buffer refuses pushes; the tail only fills behind a stalled head
  assign w_push  = i_valid && !r_tail_valid;
  assign w_pop   = r_head_valid && i_ready;
  assign o_free  = !r_tail_valid;
  assign o_empty = !r_head_valid;
  assign o_flit  = r_head_flit;
  assign o_last  = r_head_last;
  assign o_valid = r_head_valid;

  // Head/tail occupancy update for every push/pop combination
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_flit  <= '0;
      r_head_last  <= 1'b0;
      r_head_valid <= 1'b0;
      r_tail_flit  <= '0;
      r_tail_last  <= 1'b0;
      r_tail_valid <= 1'b0;
    end else if (r_tail_valid) begin
      if (w_pop) begin
        r_head_flit  <= r_tail_flit;
        r_head_last  <= r_tail_last;
        r_tail_valid <= 1'b0;
      end
    end else if (r_head_valid) begin
      case ({w_push, w_pop})
        2'b11: begin
          r_head_flit <= i_flit;
          r_head_last <= i_last;
        end
        2'b10: begin
          r_tail_flit  <= i_flit;
          r_tail_last  <= i_last;
          r_tail_valid <= 1'b1;
        end
        2'b01:   r_head_valid <= 1'b0;
        default: ;
      endcase
    end else if (w_push) begin
      r_head_flit  <= i_flit;
      r_head_last  <= i_last;
      r_head_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_packet_injector.sv
`default_nettype none
// ============================================================================
// Module      : noc_packet_injector
// Description : Per-node, per-channel packet source. Turns a descriptor
//               (dest, len) plus a payload stream into header + len payload
//               flits with last on the final flit, through a 2-entry skid
//               buffer. Descriptors with dest >= NODES are drained and
//               flagged on err_dest.
//               Optional: define NOC_INJECT_STATS_EN to add stat_pkts and
//               stat_flits handshake counters.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_packet_injector
  import noc_inject_pkg::*;
#(
  parameter  int FLIT_WIDTH = 32,
  parameter  int NODES      = 4,
  parameter  int SRC_ID     = 0,
  parameter  int MAX_LEN    = 8,
  localparam int DEST_WIDTH = dest_width(NODES),
  localparam int LEN_WIDTH  = len_width(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,       // asynchronous, active-low
  input  logic [DEST_WIDTH-1:0] req_dest,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FLIT_WIDTH-1:0] data_flit,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
`ifdef NOC_INJECT_STATS_EN
  output logic                  err_dest,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_flits
`else
  output logic                  err_dest
`endif
);

  localparam int                    c_dest_lsb = hdr_dest_lsb(FLIT_WIDTH, DEST_WIDTH);
  localparam int                    c_src_lsb  = hdr_src_lsb(FLIT_WIDTH, DEST_WIDTH);
  localparam int                    c_len_lsb  = hdr_len_lsb(FLIT_WIDTH, DEST_WIDTH, LEN_WIDTH);
  localparam logic [LEN_WIDTH-1:0]  c_max_len  = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0]  c_one      = LEN_WIDTH'(1);
  localparam logic [DEST_WIDTH:0]   c_nodes    = (DEST_WIDTH + 1)'(NODES);
  localparam logic [DEST_WIDTH-1:0] c_src      = DEST_WIDTH'(SRC_ID);

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_err;
  logic                  r_run;       // holds handshakes off until the cycle after reset
  logic                  w_free;
  logic                  w_empty;
  logic [LEN_WIDTH-1:0]  w_len;
  logic                  w_dest_ok;
  logic                  w_req_fire;
  logic                  w_data_fire;
  logic                  w_push;
  logic [FLIT_WIDTH-1:0] w_push_flit;
  logic                  w_push_last;
  logic [FLIT_WIDTH-1:0] w_header;

  assign w_dest_ok   = ({1'b0, req_dest} < c_nodes);
  assign req_ready   = r_run && (r_state == ST_IDLE) && w_free;
  assign data_ready  = r_run && (((r_state == ST_PAYLOAD) && w_free) || (r_state == ST_DROP));
  assign w_req_fire  = req_valid && req_ready;
  assign w_data_fire = data_valid && data_ready;
  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign err_dest    = r_err;

  // Oversized requests are clamped to MAX_LEN payload flits
  always_comb begin
    w_len = req_len;
    if (req_len > c_max_len) begin
      w_len = c_max_len;
    end
  end

  // Header flit: {dest, src, len} packed from the MSB, rest zero
  always_comb begin
    w_header = '0;
    w_header[c_dest_lsb +: DEST_WIDTH] = req_dest;
    w_header[c_src_lsb  +: DEST_WIDTH] = c_src;
    w_header[c_len_lsb  +: LEN_WIDTH]  = w_len;
  end

  // Select what enters the skid buffer this cycle
  always_comb begin
    w_push      = 1'b0;
    w_push_flit = data_flit;
    w_push_last = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_fire && w_dest_ok) begin
          w_push      = 1'b1;
          w_push_flit = w_header;
          w_push_last = (w_len == '0);
        end
      end
      ST_PAYLOAD: begin
        if (w_data_fire) begin
          w_push      = 1'b1;
          w_push_last = (r_cnt == c_one);
        end
      end
      default: ;
    endcase
  end

  // Packet FSM, remaining-payload counter and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_err <= !w_dest_ok;
            r_cnt <= w_len;
            if (w_len != '0) begin
              r_state <= w_dest_ok ? ST_PAYLOAD : ST_DROP;
            end
          end
        end
        ST_PAYLOAD, ST_DROP: begin
          if (w_data_fire) begin
            r_cnt <= r_cnt - c_one;
            if (r_cnt == c_one) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  noc_flit_skid #(
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_flit  (w_push_flit),
    .i_last  (w_push_last),
    .i_valid (w_push),
    .o_free  (w_free),
    .o_flit  (out_flit),
    .o_last  (out_last),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_empty (w_empty)
  );

`ifdef NOC_INJECT_STATS_EN
  logic w_out_fire;
  assign w_out_fire = out_valid && out_ready;

  // Output handshake counters; free-running and wrapping at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pkts  <= '0;
      stat_flits <= '0;
    end else if (w_out_fire) begin
      stat_flits <= stat_flits + 32'd1;
      if (out_last) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_packet_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_packet_injector
// Description : Directed self-checking bench for noc_packet_injector.
//               Main instance: NODES=4, SRC_ID=1, MAX_LEN=8, FW=32.
//               Second instance: NODES=5 so an out-of-range dest is
//               representable on the 3-bit dest port.
//               Stats checks are active when NOC_INJECT_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_packet_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_dest;
  logic [3:0]  req_len;
  logic        req_valid, req_ready;
  logic [31:0] data_flit;
  logic        data_valid, data_ready;
  logic [31:0] out_flit;
  logic        out_last, out_valid, out_ready, busy, err_dest;

  logic [2:0]  e_req_dest;
  logic [3:0]  e_req_len;
  logic        e_req_valid, e_req_ready;
  logic [31:0] e_data_flit;
  logic        e_data_valid, e_data_ready;
  logic [31:0] e_out_flit;
  logic        e_out_last, e_out_valid, e_out_ready, e_busy, e_err_dest;

`ifdef NOC_INJECT_STATS_EN
  logic [31:0] stat_pkts, stat_flits, e_stat_pkts, e_stat_flits;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          e_out_cnt = 0;
  logic [32:0] mon_q[$];
  int          mon_ts[$];
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  noc_packet_injector #(
    .FLIT_WIDTH (32), .NODES (4), .SRC_ID (1), .MAX_LEN (8)
  ) u_dut (
    .clk (clk), .rst (rst),
    .req_dest (req_dest), .req_len (req_len), .req_valid (req_valid), .req_ready (req_ready),
    .data_flit (data_flit), .data_valid (data_valid), .data_ready (data_ready),
    .out_flit (out_flit), .out_last (out_last), .out_valid (out_valid), .out_ready (out_ready),
    .busy (busy),
`ifdef NOC_INJECT_STATS_EN
    .err_dest (err_dest), .stat_pkts (stat_pkts), .stat_flits (stat_flits)
`else
    .err_dest (err_dest)
`endif
  );

  noc_packet_injector #(
    .FLIT_WIDTH (32), .NODES (5), .SRC_ID (1), .MAX_LEN (8)
  ) u_dut_err (
    .clk (clk), .rst (rst),
    .req_dest (e_req_dest), .req_len (e_req_len), .req_valid (e_req_valid), .req_ready (e_req_ready),
    .data_flit (e_data_flit), .data_valid (e_data_valid), .data_ready (e_data_ready),
    .out_flit (e_out_flit), .out_last (e_out_last), .out_valid (e_out_valid), .out_ready (e_out_ready),
    .busy (e_busy),
`ifdef NOC_INJECT_STATS_EN
    .err_dest (e_err_dest), .stat_pkts (e_stat_pkts), .stat_flits (e_stat_flits)
`else
    .err_dest (e_err_dest)
`endif
  );

  // Output monitor on the falling edge: records handshakes due at the next rising edge
  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      mon_q.push_back({out_last, out_flit});
      mon_ts.push_back(cyc);
    end
    if (e_out_valid) e_out_cnt++;
    if (rst) begin
      n_checks++;
      if (req_ready && data_ready) begin
        n_fail++;
        $display("FAIL ready_exclusive: req_ready=%b data_ready=%b required not both 1", req_ready, data_ready);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [1:0] d, input logic [3:0] l, output int waited);
    req_dest  = d;
    req_len   = l;
    req_valid = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL req_handshake: req_ready=%b required 1 within 20 cycles", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] f);
    int waited;
    data_flit  = f;
    data_valid = 1'b1;
    waited     = 0;
    while (!data_ready && waited < 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (!data_ready) begin
      n_fail++;
      $display("FAIL data_handshake: data_ready=%b required 1 within 20 cycles", data_ready);
    end
    step();
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_dest = '0; req_len = '0; req_valid = 1'b0; data_flit = '0; data_valid = 1'b0; out_ready = 1'b0;
    e_req_dest = '0; e_req_len = '0; e_req_valid = 1'b0; e_data_flit = '0; e_data_valid = 1'b0; e_out_ready = 1'b0;
    repeat (2) step();
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_last !== 1'b0)    begin n_fail++; $display("FAIL rst_out_last: got %b required 0", out_last); end
    n_checks++; if (out_flit !== 32'h0)   begin n_fail++; $display("FAIL rst_out_flit: got %h required 0", out_flit); end
    n_checks++; if (req_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
    n_checks++; if (data_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_data_ready: got %b required 0", data_ready); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_checks++; if (err_dest !== 1'b0)    begin n_fail++; $display("FAIL rst_err_dest: got %b required 0", err_dest); end
    rst = 1'b1;
    repeat (2) step();
    n_checks++; if (req_ready !== 1'b1)   begin n_fail++; $display("FAIL post_rst_req_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_basic();
    int w;
    out_ready = 1'b1;
    mon_q.delete(); mon_ts.delete();
    send_req(2'd2, 4'd3, w);
    n_checks++; if (out_valid !== 1'b1)        begin n_fail++; $display("FAIL basic_hdr_valid: got %b required 1", out_valid); end
    n_checks++; if (out_flit !== 32'h9300_0000) begin n_fail++; $display("FAIL basic_hdr_latency: got %h required 93000000", out_flit); end
    send_data(32'hA000_0001);
    send_data(32'hA000_0002);
    send_data(32'hA000_0003);
    repeat (3) step();
    exp_q = '{33'h0_9300_0000, 33'h0_A000_0001, 33'h0_A000_0002, 33'h1_A000_0003};
    n_checks++; if (mon_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d flits required 4", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_flit%0d: got {last,flit}=%h required %h", i, mon_q[i], exp_q[i]); end
    end
    n_checks++; if (mon_ts[3] - mon_ts[0] != 3) begin n_fail++; $display("FAIL basic_throughput: span %0d cycles required 3", mon_ts[3] - mon_ts[0]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_zero_len();
    int w;
    out_ready = 1'b1;
    mon_q.delete(); mon_ts.delete();
    send_req(2'd3, 4'd0, w);
    n_checks++; if (out_flit !== 32'hD000_0000) begin n_fail++; $display("FAIL zlen_hdr: got %h required D0000000", out_flit); end
    n_checks++; if (out_last !== 1'b1)   begin n_fail++; $display("FAIL zlen_last: got %b required 1", out_last); end
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL zlen_stay_idle: data_ready=%b required 0", data_ready); end
    n_checks++; if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL zlen_req_ready: got %b required 1", req_ready); end
    send_req(2'd3, 4'd0, w);
    n_checks++; if (w != 0) begin n_fail++; $display("FAIL zlen_next_req: waited %0d cycles required 0", w); end
    repeat (3) step();
    n_checks++; if (mon_q.size() != 2) begin n_fail++; $display("FAIL zlen_count: got %0d flits required 2", mon_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (mon_q[i] !== 33'h1_D000_0000) begin n_fail++; $display("FAIL zlen_flit%0d: got %h required 1D0000000", i, mon_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b1;
    mon_q.delete(); mon_ts.delete();
    send_req(2'd2, 4'd4, w);
    out_ready = 1'b0;
    send_data(32'hB000_0001);
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_data_ready: got %b required 0", data_ready); end
    n_checks++; if (req_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_full_req_ready: got %b required 0", req_ready); end
    n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL bp_busy: got %b required 1", busy); end
    data_flit  = 32'hB000_0002;
    data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b1 || out_flit !== 32'h9400_0000) begin n_fail++; $display("FAIL bp_hold%0d: valid=%b flit=%h required 1/94000000", i, out_valid, out_flit); end
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d: data_ready=%b required 0", i, data_ready); end
    end
    out_ready = 1'b1;
    send_data(32'hB000_0002);
    send_data(32'hB000_0003);
    send_data(32'hB000_0004);
    repeat (4) step();
    exp_q = '{33'h0_9400_0000, 33'h0_B000_0001, 33'h0_B000_0002, 33'h0_B000_0003, 33'h1_B000_0004};
    n_checks++; if (mon_q.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d flits required 5", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_flit%0d: got %h required %h", i, mon_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_clamp();
    int w;
    out_ready = 1'b1;
    mon_q.delete(); mon_ts.delete();
    send_req(2'd1, 4'd12, w);
    n_checks++; if (out_flit !== 32'h5800_0000) begin n_fail++; $display("FAIL clamp_hdr: got %h required 58000000", out_flit); end
    for (int i = 0; i < 8; i++) send_data(32'hC000_0000 + 32'(i));
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL clamp_end_idle: data_ready=%b required 0", data_ready); end
    repeat (3) step();
    exp_q.delete();
    exp_q.push_back(33'h0_5800_0000);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, 32'hC000_0000 + 32'(i)});
    n_checks++; if (mon_q.size() != 9) begin n_fail++; $display("FAIL clamp_count: got %0d flits required 9", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_flit%0d: got %h required %h", i, mon_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b1;
    mon_q.delete(); mon_ts.delete();
    send_req(2'd2, 4'd1, w);
    send_data(32'hE000_0001);
    send_req(2'd3, 4'd1, w);
    n_checks++; if (w != 0) begin n_fail++; $display("FAIL b2b_req_wait: waited %0d cycles required 0", w); end
    send_data(32'hE000_0002);
    repeat (3) step();
    exp_q = '{33'h0_9100_0000, 33'h1_E000_0001, 33'h0_D100_0000, 33'h1_E000_0002};
    n_checks++; if (mon_q.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d flits required 4", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_flit%0d: got %h required %h", i, mon_q[i], exp_q[i]); end
    end
    n_checks++; if (mon_ts[3] - mon_ts[0] != 3) begin n_fail++; $display("FAIL b2b_bubble: span %0d cycles required 3", mon_ts[3] - mon_ts[0]); end
  endtask

  task automatic test_illegal_dest();
    e_out_ready = 1'b1;
    e_out_cnt   = 0;
    e_req_dest  = 3'd5; e_req_len = 4'd2; e_req_valid = 1'b1;
    n_checks++; if (e_req_ready !== 1'b1) begin n_fail++; $display("FAIL bad_req_ready: got %b required 1", e_req_ready); end
    step();
    e_req_valid = 1'b0;
    n_checks++; if (e_err_dest !== 1'b1)   begin n_fail++; $display("FAIL bad_err_pulse: got %b required 1", e_err_dest); end
    n_checks++; if (e_data_ready !== 1'b1) begin n_fail++; $display("FAIL bad_drop_ready: got %b required 1", e_data_ready); end
    n_checks++; if (e_busy !== 1'b1)       begin n_fail++; $display("FAIL bad_drop_busy: got %b required 1", e_busy); end
    step();
    n_checks++; if (e_err_dest !== 1'b0)   begin n_fail++; $display("FAIL bad_err_width: got %b required 0", e_err_dest); end
    e_data_flit = 32'hF000_0001; e_data_valid = 1'b1;
    step();
    e_data_flit = 32'hF000_0002;
    step();
    e_data_valid = 1'b0;
    n_checks++; if (e_busy !== 1'b0)       begin n_fail++; $display("FAIL bad_drained_busy: got %b required 0", e_busy); end
    n_checks++; if (e_data_ready !== 1'b0) begin n_fail++; $display("FAIL bad_drained_data_ready: got %b required 0", e_data_ready); end
    n_checks++; if (e_req_ready !== 1'b1)  begin n_fail++; $display("FAIL bad_drained_req_ready: got %b required 1", e_req_ready); end
    n_checks++; if (e_out_cnt != 0)        begin n_fail++; $display("FAIL bad_no_output: out_valid cycles %0d required 0", e_out_cnt); end
    e_req_dest = 3'd7; e_req_len = 4'd0; e_req_valid = 1'b1;
    step();
    e_req_valid = 1'b0;
    n_checks++; if (e_err_dest !== 1'b1 || e_busy !== 1'b0) begin n_fail++; $display("FAIL bad_zero_len: err=%b busy=%b required 1/0", e_err_dest, e_busy); end
    e_req_dest = 3'd4; e_req_len = 4'd0; e_req_valid = 1'b1;
    step();
    e_req_valid = 1'b0;
    n_checks++; if (e_out_valid !== 1'b1 || e_out_flit !== 32'h8400_0000 || e_out_last !== 1'b1) begin n_fail++; $display("FAIL edge_dest_hdr: valid=%b flit=%h last=%b required 1/84000000/1", e_out_valid, e_out_flit, e_out_last); end
    n_checks++; if (e_err_dest !== 1'b0) begin n_fail++; $display("FAIL edge_dest_err: got %b required 0", e_err_dest); end
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b0;
    mon_q.delete(); mon_ts.delete();
    send_req(2'd2, 4'd3, w);
    send_data(32'hD000_00AA);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_flit !== 32'h0)  begin n_fail++; $display("FAIL mid_rst_out_flit: got %h required 0", out_flit); end
    n_checks++; if (out_last !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_out_last: got %b required 0", out_last); end
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b0 || data_ready !== 1'b0 || err_dest !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ctrl: busy=%b req_ready=%b data_ready=%b err=%b required 0", busy, req_ready, data_ready, err_dest);
    end
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (2) step();
    send_req(2'd1, 4'd1, w);
    n_checks++; if (out_flit !== 32'h5100_0000) begin n_fail++; $display("FAIL mid_rst_new_hdr: got %h required 51000000", out_flit); end
    send_data(32'h1234_5678);
    repeat (3) step();
    exp_q = '{33'h0_5100_0000, 33'h1_1234_5678};
    n_checks++; if (mon_q.size() != 2) begin n_fail++; $display("FAIL mid_rst_count: got %0d flits required 2", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_rst_flit%0d: got %h required %h", i, mon_q[i], exp_q[i]); end
    end
  endtask

`ifdef NOC_INJECT_STATS_EN
  task automatic test_stats();
    int w;
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (2) step();
    n_checks++; if (stat_pkts !== 32'd0 || stat_flits !== 32'd0) begin n_fail++; $display("FAIL stats_reset: pkts=%0d flits=%0d required 0/0", stat_pkts, stat_flits); end
    out_ready = 1'b1;
    send_req(2'd2, 4'd0, w);
    send_req(2'd2, 4'd2, w);
    for (int i = 0; i < 2; i++) send_data(32'h5500_0000 + 32'(i));
    send_req(2'd3, 4'd8, w);
    for (int i = 0; i < 8; i++) send_data(32'h6600_0000 + 32'(i));
    repeat (3) step();
    n_checks++; if (stat_pkts !== 32'd3)   begin n_fail++; $display("FAIL stats_pkts: got %0d required 3", stat_pkts); end
    n_checks++; if (stat_flits !== 32'd13) begin n_fail++; $display("FAIL stats_flits: got %0d required 13", stat_flits); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_clamp();
    test_back_to_back();
    test_illegal_dest();
    test_reset_mid();
`ifdef NOC_INJECT_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
